// File: rtl/weight_fetch_pkg.sv
// Shared defaults and state encoding for the weight fetch controller.
package weight_fetch_pkg;

    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 5;
    localparam int DEPTH_DEF = 28;

    // IDLE waits for START, FETCH issues BRAM reads, DRAIN empties the FIFO
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO holding {index, last, data} for one BRAM read each.
// The head entry is presented combinationally; pops of an empty FIFO are ignored.
module weight_skid_fifo #(
    parameter int DW = 16,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic [AW-1:0] push_index,
    input  logic          push_last,
    input  logic          pop,
    output logic [1:0]    count,
    output logic [DW-1:0] head_data,
    output logic [AW-1:0] head_index,
    output logic          head_last
);

    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_pop;

    assign do_pop = pop && (count_q != 2'd0);

    // Pointer and occupancy bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Register pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // One storage slot per entry; a slot only loads when the write pointer selects it
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [DW-1:0] data_q, data_d;
        logic [AW-1:0] index_q, index_d;
        logic          last_q, last_d;

        // Load this slot on a push that targets it
        always_comb begin
            data_d  = data_q;
            index_d = index_q;
            last_d  = last_q;
            if (push && (wr_ptr_q == 1'(gi))) begin
                data_d  = push_data;
                index_d = push_index;
                last_d  = push_last;
            end
        end

        // Slot storage
        always_ff @(posedge clk) begin
            if (!rstn) begin
                data_q  <= '0;
                index_q <= '0;
                last_q  <= 1'b0;
            end else begin
                data_q  <= data_d;
                index_q <= index_d;
                last_q  <= last_d;
            end
        end
    end

    // Head selection
    always_comb begin
        head_data  = g_entry[0].data_q;
        head_index = g_entry[0].index_q;
        head_last  = g_entry[0].last_q;
        if (rd_ptr_q) begin
            head_data  = g_entry[1].data_q;
            head_index = g_entry[1].index_q;
            head_last  = g_entry[1].last_q;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Sweeps a weight BRAM from address 0 to DEPTH-1 and streams the words to the
// MAC over valid/ready. Reads have one cycle of latency (address at edge k,
// data captured at edge k+1); a credit check keeps the 2-entry FIFO from
// overflowing while still allowing one beat per cycle.
module weight_fetch_ctrl
    import weight_fetch_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE,
    output logic [AW-1:0] ADDR,
    output logic          EN,
    output logic          WE,
    output logic [DW-1:0] DI,
    input  logic [DW-1:0] DO,
    output logic [DW-1:0] W_DATA,
    output logic [AW-1:0] W_INDEX,
    output logic          W_VALID,
    input  logic          W_READY,
    output logic          W_LAST
);

    state_e        state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          en_q, en_d;
    logic [AW-1:0] cnt_q, cnt_d;          // next address to issue
    logic          inflight_q, inflight_d;  // a read issued last cycle lands now

    logic [1:0]    fifo_count;
    logic          pop;
    logic          push_last;
    logic [2:0]    credit_need;
    logic [2:0]    credit_avail;
    logic          credit_ok;

    assign W_VALID   = (fifo_count != 2'd0);
    assign pop       = W_VALID && W_READY;
    assign push_last = (addr_q == AW'(DEPTH - 1));

    // Entries that will occupy the FIFO after this edge must leave room for one more
    assign credit_need  = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign credit_avail = 3'd1 + {2'b00, pop};
    assign credit_ok    = (credit_need <= credit_avail);

    weight_skid_fifo #(
        .DW(DW),
        .AW(AW)
    ) u_fifo (
        .clk        (CLK),
        .rstn       (RSTN),
        .push       (inflight_q),
        .push_data  (DO),
        .push_index (addr_q),
        .push_last  (push_last),
        .pop        (pop),
        .count      (fifo_count),
        .head_data  (W_DATA),
        .head_index (W_INDEX),
        .head_last  (W_LAST)
    );

    // Next-state and registered-output logic for the sweep FSM
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        addr_d     = addr_q;
        en_d       = 1'b0;
        cnt_d      = cnt_q;
        inflight_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    busy_d     = 1'b1;
                    addr_d     = '0;
                    en_d       = 1'b1;
                    inflight_d = 1'b1;
                    cnt_d      = AW'(1);
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (credit_ok) begin
                    addr_d     = cnt_q;
                    en_d       = 1'b1;
                    inflight_d = 1'b1;
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                addr_d = '0;
                if (pop && W_LAST) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                addr_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset discards any sweep in progress
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            en_q       <= 1'b0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            en_q       <= en_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign ADDR = addr_q;
    assign EN   = en_q;
    assign WE   = 1'b0;
    assign DI   = '0;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed/random bench for weight_fetch_ctrl with a falling-edge BRAM model
// and a stream-level reference: a sweep must deliver mem[0..27] in order,
// DONE one cycle after the last handshake, BUSY from accept to DONE.
module tb_weight_fetch_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 28;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          START;
    logic          BUSY;
    logic          DONE;
    logic [AW-1:0] ADDR;
    logic          EN;
    logic          WE;
    logic [DW-1:0] DI;
    logic [DW-1:0] DO;
    logic [DW-1:0] W_DATA;
    logic [AW-1:0] W_INDEX;
    logic          W_VALID;
    logic          W_READY;
    logic          W_LAST;

    logic [DW-1:0] mem [DEPTH];

    int   total = 0;
    int   bad   = 0;
    logic busy_m = 1'b0;
    int   exp_idx = 0;
    int   beats = 0;
    int   dones = 0;

    weight_fetch_ctrl dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .START   (START),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ADDR    (ADDR),
        .EN      (EN),
        .WE      (WE),
        .DI      (DI),
        .DO      (DO),
        .W_DATA  (W_DATA),
        .W_INDEX (W_INDEX),
        .W_VALID (W_VALID),
        .W_READY (W_READY),
        .W_LAST  (W_LAST)
    );

    always #5 CLK = ~CLK;

    // BRAM read port updates on the falling edge
    always @(negedge CLK) begin
        if (EN) DO <= mem[ADDR];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem(input logic rnd);
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = rnd ? 16'($urandom) : 16'(16'h0100 + i);
        end
    endtask

    // One clock cycle: drive inputs, score any handshake, then check after the edge
    task automatic cyc(input logic rs, input logic st, input logic rd);
        logic          hs, dn, acc, stall;
        logic [DW-1:0] sd;
        logic [AW-1:0] si;
        RSTN    = rs;
        START   = st;
        W_READY = rd;
        hs    = rs && (W_VALID === 1'b1) && rd;
        stall = rs && (W_VALID === 1'b1) && !rd;
        sd    = W_DATA;
        si    = W_INDEX;
        dn    = 1'b0;
        if (hs) begin
            chk("beat_index", 32'(W_INDEX), 32'(exp_idx));
            if (exp_idx < DEPTH) chk("beat_data", 32'(W_DATA), 32'(mem[exp_idx]));
            chk("beat_last", 32'(W_LAST), 32'(exp_idx == DEPTH - 1));
            $display("beat index=%0d data=%04h last=%0b", W_INDEX, W_DATA, W_LAST);
            dn = (exp_idx == DEPTH - 1);
            exp_idx++;
            beats++;
        end
        acc = rs && st && !busy_m;
        @(posedge CLK);
        #1;
        if (!rs) begin
            busy_m  = 1'b0;
            exp_idx = 0;
            chk("rst_busy", 32'(BUSY), 0);
            chk("rst_done", 32'(DONE), 0);
            chk("rst_en", 32'(EN), 0);
            chk("rst_valid", 32'(W_VALID), 0);
            chk("rst_addr", 32'(ADDR), 0);
            chk("rst_last", 32'(W_LAST), 0);
        end else begin
            if (acc) begin
                busy_m  = 1'b1;
                exp_idx = 0;
                beats   = 0;
                chk("issue_en", 32'(EN), 1);
                chk("issue_addr", 32'(ADDR), 0);
            end
            if (dn) begin
                busy_m = 1'b0;
                dones++;
            end
            chk("done", 32'(DONE), 32'(dn));
            chk("busy", 32'(BUSY), 32'(busy_m));
            chk("we_zero", 32'(WE), 0);
            chk("di_zero", 32'(DI), 0);
            chk("fifo_bound", 32'(dut.fifo_count <= 2'd2), 1);
            if (stall) begin
                chk("hold_valid", 32'(W_VALID), 1);
                chk("hold_index", 32'(W_INDEX), 32'(si));
                chk("hold_data", 32'(W_DATA), 32'(sd));
            end
        end
    endtask

    task automatic run_to_done(input logic rnd, input int limit);
        int n;
        int d0;
        n  = 0;
        d0 = dones;
        while (dones == d0 && n < limit) begin
            cyc(1'b1, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        chk("sweep_completes", 32'(dones - d0), 1);
        chk("sweep_beats", 32'(beats), 32'(DEPTH));
    endtask

    task automatic until_head(input int idx, input int limit);
        int n;
        n = 0;
        while (!(W_VALID === 1'b1 && W_INDEX == AW'(idx)) && n < limit) begin
            cyc(1'b1, 1'b0, 1'b1);
            n++;
        end
        chk("head_reached", 32'(W_INDEX), 32'(idx));
    endtask

    initial begin
        logic [AW-1:0] addr_hold;
        int            d0;
        RSTN    = 1'b0;
        START   = 1'b1;
        W_READY = 1'b0;
        fill_mem(1'b0);

        // Reset held with START asserted
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("idle_en", 32'(EN), 0);

        // Full-rate sweep
        cyc(1'b1, 1'b1, 1'b1);
        for (int n = 1; n <= DEPTH; n++) begin
            cyc(1'b1, 1'b0, 1'b1);
            chk("full_rate_valid", 32'(W_VALID), 1);
        end
        cyc(1'b1, 1'b0, 1'b1);
        chk("done_edge29", 32'(DONE), 1);
        chk("busy_edge29", 32'(BUSY), 0);
        chk("full_rate_beats", 32'(beats), 32'(DEPTH));
        cyc(1'b1, 1'b0, 1'b1);
        chk("after_done_valid", 32'(W_VALID), 0);

        // Backpressure with index 10 at the head
        fill_mem(1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        until_head(10, 40);
        addr_hold = '0;
        for (int s = 0; s < 5; s++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (s == 0) begin
                addr_hold = ADDR;
                chk("stall_addr_bound", 32'(ADDR <= AW'(12)), 1);
            end else begin
                chk("stall_en", 32'(EN), 0);
                chk("stall_addr", 32'(ADDR), 32'(addr_hold));
            end
            chk("stall_head", 32'(W_INDEX), 10);
        end
        chk("stall_fifo_full", 32'(dut.fifo_count), 2);
        run_to_done(1'b0, 100);

        // Random backpressure, three sweeps
        for (int sw = 0; sw < 3; sw++) begin
            fill_mem(1'b1);
            cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)));
            run_to_done(1'b1, 400);
        end

        // START while busy is ignored
        fill_mem(1'b1);
        d0 = dones;
        cyc(1'b1, 1'b1, 1'b1);
        until_head(5, 40);
        cyc(1'b1, 1'b1, 1'b1);
        run_to_done(1'b0, 100);
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        chk("single_done", 32'(dones - d0), 1);

        // Reset mid-sweep, then a fresh sweep
        fill_mem(1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        until_head(15, 40);
        d0 = dones;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("post_rst_valid", 32'(W_VALID), 0);
        chk("post_rst_done", 32'(DONE), 0);
        fill_mem(1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("restart_index", 32'(W_INDEX), 0);
        run_to_done(1'b0, 100);
        chk("restart_done_count", 32'(dones - d0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
